// File: rtl/wb_stage.sv
// Writeback stage: selects load vs ALU data for the register-file write port, keeps a
// one-entry forwarding register, registers the retire record and counts retired instructions.
module wb_stage #(
   parameter int unsigned CNT_W  = 64,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_vld,
   input  logic             i_mem_reg,
   input  logic [31:0]      i_res,
   input  logic [31:0]      i_dmem_rdata,
   input  logic [4:0]       i_rd_waddr,
   input  logic             i_rd_wen,
   input  logic [31:0]      i_inst,
   input  logic [31:0]      i_pc,
   input  logic [31:0]      i_nxt_pc,
   input  logic             i_break,
   input  logic             i_resume,
   output logic [4:0]       o_rd_waddr,
   output logic [31:0]      o_rd_wdata,
   output logic             o_rd_wen,
   output logic             o_fwd_vld,
   output logic [4:0]       o_fwd_waddr,
   output logic [31:0]      o_fwd_wdata,
   output logic             o_retire,
   output logic [31:0]      o_retire_pc,
   output logic [31:0]      o_retire_inst,
   output logic [31:0]      o_retire_nxt_pc,
   output logic [CNT_W-1:0] o_instret,
   output logic             o_halt
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic               accept;
   logic [31:0]        wdata;
   logic               rd_wen;
   logic               fwd_vld_q;
   logic [4:0]         fwd_waddr_q;
   logic [31:0]        fwd_wdata_q;
   logic               retire_q;
   logic [31:0]        retire_pc_q, retire_inst_q, retire_nxt_pc_q;
   logic [CNT_W-1:0]   instret_q, instret_d;

   // accept looks at the current state, so an entry arriving with i_resume in HALT is dropped
   assign accept = i_vld & (state_q == RUN);
   assign wdata  = i_mem_reg ? i_dmem_rdata : i_res;
   assign rd_wen = accept & i_rd_wen & (i_rd_waddr != 5'd0);

   assign o_rd_waddr = i_rd_waddr;
   assign o_rd_wdata = wdata;
   assign o_rd_wen   = rd_wen;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (accept & i_break) state_d = HALT;
         HALT:    if (i_resume)         state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // counter wraps silently at all-ones
   assign instret_d = accept ? instret_q + 1'b1 : instret_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q         <= RUN;
         fwd_vld_q       <= 1'b0;
         fwd_waddr_q     <= 5'd0;
         fwd_wdata_q     <= 32'd0;
         retire_q        <= 1'b0;
         retire_pc_q     <= 32'd0;
         retire_inst_q   <= 32'd0;
         retire_nxt_pc_q <= 32'd0;
         instret_q       <= '0;
      end else begin
         state_q   <= state_d;
         fwd_vld_q <= FWD_EN & rd_wen;
         if (rd_wen) begin
            fwd_waddr_q <= i_rd_waddr;
            fwd_wdata_q <= wdata;
         end
         retire_q <= accept;
         if (accept) begin
            retire_pc_q     <= i_pc;
            retire_inst_q   <= i_inst;
            retire_nxt_pc_q <= i_nxt_pc;
         end
         instret_q <= instret_d;
      end
   end

   assign o_fwd_vld       = fwd_vld_q;
   assign o_fwd_waddr     = fwd_waddr_q;
   assign o_fwd_wdata     = fwd_wdata_q;
   assign o_retire        = retire_q;
   assign o_retire_pc     = retire_pc_q;
   assign o_retire_inst   = retire_inst_q;
   assign o_retire_nxt_pc = retire_nxt_pc_q;
   assign o_instret       = instret_q;
   assign o_halt          = (state_q == HALT);

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 64-bit counter instance and a 4-bit counter instance share stimulus.
module tb_wb_stage;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_vld = 1'b0, i_mem_reg = 1'b0, i_rd_wen = 1'b0, i_break = 1'b0, i_resume = 1'b0;
   logic [31:0] i_res = '0, i_dmem_rdata = '0, i_inst = '0, i_pc = '0, i_nxt_pc = '0;
   logic [4:0]  i_rd_waddr = '0;

   logic [4:0]  o_rd_waddr, o_fwd_waddr, s_rd_waddr, s_fwd_waddr;
   logic [31:0] o_rd_wdata, o_fwd_wdata, o_retire_pc, o_retire_inst, o_retire_nxt_pc;
   logic [31:0] s_rd_wdata, s_fwd_wdata, s_retire_pc, s_retire_inst, s_retire_nxt_pc;
   logic        o_rd_wen, o_fwd_vld, o_retire, o_halt;
   logic        s_rd_wen, s_fwd_vld, s_retire, s_halt;
   logic [63:0] o_instret;
   logic [3:0]  s_instret;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   wb_stage #(.CNT_W(64), .FWD_EN(1'b1)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_reg(i_mem_reg), .i_res(i_res),
      .i_dmem_rdata(i_dmem_rdata), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst),
      .i_pc(i_pc), .i_nxt_pc(i_nxt_pc), .i_break(i_break), .i_resume(i_resume),
      .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata), .o_rd_wen(o_rd_wen),
      .o_fwd_vld(o_fwd_vld), .o_fwd_waddr(o_fwd_waddr), .o_fwd_wdata(o_fwd_wdata),
      .o_retire(o_retire), .o_retire_pc(o_retire_pc), .o_retire_inst(o_retire_inst),
      .o_retire_nxt_pc(o_retire_nxt_pc), .o_instret(o_instret), .o_halt(o_halt)
   );

   wb_stage #(.CNT_W(4), .FWD_EN(1'b1)) dut_small (
      .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_reg(i_mem_reg), .i_res(i_res),
      .i_dmem_rdata(i_dmem_rdata), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst),
      .i_pc(i_pc), .i_nxt_pc(i_nxt_pc), .i_break(i_break), .i_resume(i_resume),
      .o_rd_waddr(s_rd_waddr), .o_rd_wdata(s_rd_wdata), .o_rd_wen(s_rd_wen),
      .o_fwd_vld(s_fwd_vld), .o_fwd_waddr(s_fwd_waddr), .o_fwd_wdata(s_fwd_wdata),
      .o_retire(s_retire), .o_retire_pc(s_retire_pc), .o_retire_inst(s_retire_inst),
      .o_retire_nxt_pc(s_retire_nxt_pc), .o_instret(s_instret), .o_halt(s_halt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic memreg, input logic [31:0] res,
                        input logic [31:0] rdata, input logic [4:0] rd, input logic wen,
                        input logic [31:0] pc, input logic brk, input logic resume);
      i_vld = vld; i_mem_reg = memreg; i_res = res; i_dmem_rdata = rdata;
      i_rd_waddr = rd; i_rd_wen = wen; i_pc = pc; i_inst = pc ^ 32'hA5A5_0013;
      i_nxt_pc = pc + 32'd4; i_break = brk; i_resume = resume;
      #1;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   int retire_cnt;

   initial begin
      #12;
      chk("rst_halt", o_halt, 0);
      chk("rst_retire", o_retire, 0);
      chk("rst_fwd_vld", o_fwd_vld, 0);
      chk("rst_instret", o_instret, 0);
      chk("rst_retire_pc", o_retire_pc, 0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      // load then ALU
      drive(1, 1, 32'h55, 32'hDEADBEEF, 5'd5, 1, 32'h10, 0, 0);
      chk("ld_wen", o_rd_wen, 1);
      chk("ld_waddr", o_rd_waddr, 5);
      chk("ld_wdata", o_rd_wdata, 32'hDEADBEEF);
      tick();
      chk("ld_fwd_vld", o_fwd_vld, 1);
      chk("ld_fwd_waddr", o_fwd_waddr, 5);
      chk("ld_fwd_wdata", o_fwd_wdata, 32'hDEADBEEF);
      chk("ld_retire", o_retire, 1);
      chk("ld_retire_pc", o_retire_pc, 32'h10);
      chk("ld_retire_inst", o_retire_inst, 32'h10 ^ 32'hA5A5_0013);
      chk("ld_retire_nxt", o_retire_nxt_pc, 32'h14);
      chk("ld_instret", o_instret, 1);
      drive(1, 0, 32'h12, 32'hDEADBEEF, 5'd6, 1, 32'h14, 0, 0);
      chk("alu_wdata", o_rd_wdata, 32'h12);
      chk("alu_wen", o_rd_wen, 1);
      tick();
      chk("alu_fwd_waddr", o_fwd_waddr, 6);
      chk("alu_fwd_wdata", o_fwd_wdata, 32'h12);
      chk("alu_instret", o_instret, 2);

      // write to x0
      drive(1, 0, 32'h99, 32'h0, 5'd0, 1, 32'h18, 0, 0);
      chk("x0_wen", o_rd_wen, 0);
      tick();
      chk("x0_fwd_vld", o_fwd_vld, 0);
      chk("x0_retire", o_retire, 1);
      chk("x0_retire_pc", o_retire_pc, 32'h18);
      chk("x0_instret", o_instret, 3);

      // bubbles: V I V I V
      retire_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         logic v;
         logic [31:0] exp_pc;
         v = (k % 2 == 0);
         exp_pc = 32'h20 + 32'(k / 2) * 32'h4;
         drive(v, 0, 32'h40 + 32'(k), 32'h0, 5'd3, 1, v ? exp_pc : 32'hBAD0, 0, 0);
         chk("bub_wen", o_rd_wen, v);
         tick();
         chk("bub_retire", o_retire, v);
         chk("bub_retire_pc", o_retire_pc, exp_pc);
         if (o_retire) retire_cnt++;
      end
      chk("bub_retire_cnt", retire_cnt, 3);
      chk("bub_instret", o_instret, 6);

      // break at 0x100 with a register write
      drive(1, 0, 32'h77, 32'h0, 5'd7, 1, 32'h100, 1, 0);
      chk("brk_wen", o_rd_wen, 1);
      tick();
      chk("brk_halt", o_halt, 1);
      chk("brk_retire", o_retire, 1);
      chk("brk_retire_pc", o_retire_pc, 32'h100);
      chk("brk_fwd_wdata", o_fwd_wdata, 32'h77);
      chk("brk_instret", o_instret, 7);
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 32'h88, 32'h0, 5'd8, 1, 32'h104, 0, 0);
         chk("hlt_wen", o_rd_wen, 0);
         tick();
         chk("hlt_halt", o_halt, 1);
         chk("hlt_retire", o_retire, 0);
         chk("hlt_fwd_vld", o_fwd_vld, 0);
         chk("hlt_retire_pc", o_retire_pc, 32'h100);
         chk("hlt_instret", o_instret, 7);
      end
      // resume with a valid entry: entry dropped
      drive(1, 0, 32'h88, 32'h0, 5'd8, 1, 32'h104, 0, 1);
      chk("res_wen", o_rd_wen, 0);
      tick();
      chk("res_halt", o_halt, 0);
      chk("res_retire", o_retire, 0);
      chk("res_instret", o_instret, 7);
      drive(1, 0, 32'h9, 32'h0, 5'd9, 1, 32'h108, 0, 0);
      chk("post_res_wen", o_rd_wen, 1);
      tick();
      chk("post_res_retire_pc", o_retire_pc, 32'h108);
      chk("post_res_instret", o_instret, 8);
      // resume in RUN has no effect
      drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 1);
      tick();
      chk("run_res_halt", o_halt, 0);

      // break retiring together with resume: halts anyway
      drive(1, 0, 32'hAB, 32'h0, 5'd10, 1, 32'h200, 1, 1);
      tick();
      chk("brkres_halt", o_halt, 1);
      chk("brkres_instret", o_instret, 9);
      chk("brkres_fwd_vld", o_fwd_vld, 1);

      // async reset mid-HALT with a pending entry
      drive(1, 0, 32'h1, 32'h0, 5'd11, 1, 32'h204, 0, 0);
      i_rst = 1'b1;
      #1;
      chk("arst_halt", o_halt, 0);
      chk("arst_retire", o_retire, 0);
      chk("arst_fwd_vld", o_fwd_vld, 0);
      chk("arst_instret", o_instret, 0);
      chk("arst_small_instret", s_instret, 0);
      tick();
      i_rst = 1'b0;
      drive(1, 0, 32'h31, 32'h0, 5'd12, 1, 32'h300, 0, 0);
      chk("arst_post_wen", o_rd_wen, 1);
      tick();
      chk("arst_post_retire", o_retire, 1);
      chk("arst_post_retire_pc", o_retire_pc, 32'h300);
      chk("arst_post_instret", o_instret, 1);

      // 16 more accepts: 17 total since reset
      for (int k = 0; k < 16; k++) begin
         drive(1, 0, 32'(k), 32'h0, 5'd1, 1, 32'h400 + 32'(k) * 32'h4, 0, 0);
         tick();
      end
      chk("wrap_small_instret", s_instret, 1);
      chk("wrap_big_instret", o_instret, 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage, directly downstream of the memory stage's MEM/WB register.
- Selects load data vs ALU result and drives the register-file write port (combinational, same cycle).
- Holds a one-entry forwarding register for the previous writeback.
- Registers a retire/trace record, counts retired instructions, and runs a halt FSM triggered by a retiring break instruction.

Parameters:
- CNT_W, 64, width of retired-instruction counter
- FWD_EN, 1, 1 = forwarding register active; 0 = o_fwd_vld tied 0

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_vld  input  1  MEM/WB entry valid
- i_mem_reg  input  1  1 = write load data, 0 = write i_res
- i_res  input  32  ALU/PC-link result
- i_dmem_rdata  input  32  aligned, extended load data
- i_rd_waddr  input  5  destination register
- i_rd_wen  input  1  destination write request
- i_inst  input  32  instruction word
- i_pc  input  32  instruction PC
- i_nxt_pc  input  32  next PC
- i_break  input  1  instruction is ebreak
- i_resume  input  1  leave HALT
- o_rd_waddr  output  5  register-file write address
- o_rd_wdata  output  32  register-file write data
- o_rd_wen  output  1  register-file write enable
- o_fwd_vld  output  1  forwarding register valid
- o_fwd_waddr  output  5  forwarded register
- o_fwd_wdata  output  32  forwarded data
- o_retire  output  1  registered retire pulse
- o_retire_pc  output  32  retired PC
- o_retire_inst  output  32  retired instruction
- o_retire_nxt_pc  output  32  retired next PC
- o_instret  output  CNT_W  retired count
- o_halt  output  1  core halted (FSM in HALT)

Behaviour:
- Reset: all outputs 0; FSM = RUN. Counter, forwarding and retire registers clear asynchronously.
- Definitions:
  - wdata = i_mem_reg ? i_dmem_rdata : i_res
  - accept = i_vld & (state == RUN)
- Register-file write (combinational, zero latency):
  - o_rd_wen = accept & i_rd_wen & (i_rd_waddr != 0)
  - o_rd_waddr = i_rd_waddr; o_rd_wdata = wdata
- Forwarding register (1 cycle latency):
  - When o_rd_wen: capture waddr/wdata and set o_fwd_vld = 1.
  - Otherwise o_fwd_vld = 0 next cycle.
  - Writes to x0 never set o_fwd_vld.
- Retire record (1 cycle latency):
  - o_retire = accept registered.
  - pc/inst/nxt_pc are captured only when accept; they hold otherwise.
- Counter:
  - o_instret increments by 1 on each accept, including the break instruction itself.
  - Wraps from all-ones to 0 without a flag.
- FSM RUN:
  - accept & i_break -> HALT next cycle. The break's writeback and retire still occur.
- FSM HALT:
  - o_halt = 1. All i_vld ignored: no writes, no retire, no count.
  - i_resume -> RUN next cycle.
  - i_resume while in RUN has no effect.
- Simultaneous events:
  - i_resume in HALT together with i_vld: the entry is ignored, because accept uses the current state.
  - Break retires on the same edge as i_resume: the transition is RUN->HALT; resume is ignored.
- Stall bubbles: upstream stall arrives as i_vld = 0; a stalled cycle never counts.
- Reset mid-operation: asynchronous clear overrides everything. FSM goes to RUN; o_halt, o_retire and o_fwd_vld drop immediately, without waiting for a clock edge.

Test Plan:
- Load then ALU:
  - i_vld=1, mem_reg=1, dmem_rdata=0xDEADBEEF, rd=5 -> same cycle o_rd_wen=1, wdata=0xDEADBEEF.
  - Next: mem_reg=0, res=0x12 -> wdata=0x12.
  - o_fwd_* track each write one cycle later.
- x0 write: rd=0, rd_wen=1, vld=1 -> o_rd_wen=0, o_fwd_vld=0, o_retire=1, o_instret +1.
- Bubbles: 3 valid / 2 invalid cycles interleaved -> o_instret=3, o_retire pulses exactly 3 times with the correct PCs.
- Break:
  - Break at pc=0x100 with rd write -> write occurs, retire pc=0x100, o_halt=1 next cycle.
  - Following vld entries -> no writes, count frozen.
  - i_resume pulse -> RUN; next entry retires.
- Wrap: CNT_W=4, 17 accepts -> o_instret=1.
- Async reset mid-HALT with pending vld -> o_halt, o_retire, o_fwd_vld, o_instret all 0 before the next edge; first post-reset entry retires normally.
